// File: rtl/accum_array_pkg.sv
// Shared types and constants for the accumulator array and its dump engine.
package accum_array_pkg;
    localparam int LANES   = 8;
    localparam int ENTRY_W = 64;
    localparam int LANE_W  = $clog2(LANES);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DRAIN, ST_DUMP} state_e;

    typedef logic [LANES-1:0][ENTRY_W-1:0] row_t;
endpackage

// File: rtl/accum_ram.sv
// Counter storage: DEPTH x 64-bit entries, written one entry at a time and read a full
// 8-entry row per cycle (asymmetric simple dual-port, 1-cycle registered read).
module accum_ram
    import accum_array_pkg::*;
#(
    parameter int  DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int ROW_W  = (ADDR_W > LANE_W) ? ADDR_W - LANE_W : 1
) (
    input  logic                       clk_i,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [ENTRY_W-1:0]         wr_data_i,
    input  logic [ROW_W-1:0]           rd_row_i,
    output logic [LANES*ENTRY_W-1:0]   rd_data_o
);
    localparam int ROWS = DEPTH / LANES;

    row_t mem [ROWS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i)
            mem[ROW_W'(wr_addr_i >> LANE_W)][wr_addr_i[LANE_W-1:0]] <= wr_data_i;
        rd_data_o <= mem[rd_row_i];
    end
endmodule

// File: rtl/accum_array.sv
// Accumulator array: 2-stage read-modify-write counter updates, bulk clear, and an
// AXI-Stream dump of 8 entries per beat.
module accum_array
    import accum_array_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  accum_addr,
    input  logic [63:0]  accum_din,
    input  logic         accum_we,
    input  logic         clear_kick,
    input  logic         dump_kick,
    input  logic [31:0]  dump_words,
    output logic         busy,
    output logic [31:0]  drop_count,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [511:0] m_axis_tdata,
    output logic         m_axis_tlast
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ROW_W  = (ADDR_W > LANE_W) ? ADDR_W - LANE_W : 1;

    state_e              state_q, state_d;
    logic                drain_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic [ADDR_W:0]     words_q, words_clamp, words_sum;
    logic [ROW_W:0]      nrows_q, iss_row_q;
    logic                s1_vld_q, wb_vld_q, rd_pend_q;
    logic [ADDR_W-1:0]   s1_addr_q, wb_addr_q;
    logic [ENTRY_W-1:0]  s1_din_q, wb_data_q;
    logic [ROW_W-1:0]    rd_row, rd_row_q;
    row_t                ram_rd, rd_fwd, arr_data, out_data_q, hold_data_q;
    logic                arr_last;
    logic                out_vld_q, out_last_q, hold_vld_q, hold_last_q;
    logic                strobe_ok, clr_wr, pop, issue;
    logic [1:0]          occ;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ENTRY_W-1:0]  wr_data, sum;
    logic [31:0]         drop_q;

    assign strobe_ok = accum_we && (state_q == ST_IDLE || state_q == ST_DRAIN)
                       && (accum_addr < 32'(DEPTH));
    // A pending RMW write owns the write port; clear simply waits one cycle.
    assign clr_wr    = (state_q == ST_CLEAR) && !s1_vld_q;
    assign pop       = out_vld_q && m_axis_tready;
    assign occ       = 2'(out_vld_q) + 2'(hold_vld_q) + 2'(rd_pend_q);
    assign issue     = (state_q == ST_DUMP) && (iss_row_q != nrows_q) && ((occ - 2'(pop)) < 2'd2);
    assign rd_row    = (state_q == ST_DUMP) ? ROW_W'(iss_row_q) : ROW_W'(accum_addr >> LANE_W);

    assign sum     = rd_fwd[s1_addr_q[LANE_W-1:0]] + s1_din_q;
    assign wr_en   = s1_vld_q || clr_wr;
    assign wr_addr = s1_vld_q ? s1_addr_q : clr_idx_q;
    assign wr_data = s1_vld_q ? sum : '0;

    assign words_clamp = (dump_words > 32'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : dump_words[ADDR_W:0];
    assign words_sum   = words_clamp + (ADDR_W+1)'(LANES-1);

    accum_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_row_i  (rd_row),
        .rd_data_o (ram_rd)
    );

    // The RAM returns pre-write data when a read and write hit the same edge; patch in
    // the lane written on that edge so both RMW and dump see the latest value.
    always_comb begin
        rd_fwd = ram_rd;
        if (wb_vld_q && ROW_W'(wb_addr_q >> LANE_W) == rd_row_q)
            rd_fwd[wb_addr_q[LANE_W-1:0]] = wb_data_q;
    end

    always_comb begin
        arr_data = '0;
        for (int l = 0; l < LANES; l++)
            if ((ADDR_W+1)'({rd_row_q, LANE_W'(l)}) < words_q)
                arr_data[l] = rd_fwd[l];
        arr_last = ((ROW_W+1)'(rd_row_q) == nrows_q - (ROW_W+1)'(1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_kick) state_d = ST_CLEAR;
                      else if (dump_kick) state_d = ST_DRAIN;
            ST_CLEAR: if (clr_wr && clr_idx_q == ADDR_W'(DEPTH-1)) state_d = ST_IDLE;
            ST_DRAIN: if (drain_q) state_d = (nrows_q == '0) ? ST_IDLE : ST_DUMP;
            ST_DUMP:  if (pop && out_last_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        s1_addr_q <= accum_addr[ADDR_W-1:0];
        s1_din_q  <= accum_din;
        wb_addr_q <= wr_addr;
        wb_data_q <= wr_data;
        rd_row_q  <= rd_row;
        if (state_q == ST_IDLE && dump_kick && !clear_kick) begin
            words_q <= words_clamp;
            nrows_q <= (ROW_W+1)'(words_sum >> LANE_W);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_q     <= 1'b0;
            clr_idx_q   <= '0;
            s1_vld_q    <= 1'b0;
            wb_vld_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            iss_row_q   <= '0;
            drop_q      <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_last_q <= 1'b0;
        end else begin
            drain_q   <= (state_q == ST_DRAIN) && !drain_q;
            s1_vld_q  <= strobe_ok;
            wb_vld_q  <= wr_en;
            rd_pend_q <= issue;
            if (accum_we && !strobe_ok) drop_q <= drop_q + 32'd1;
            if (state_q != ST_CLEAR) clr_idx_q <= '0;
            else if (clr_wr)         clr_idx_q <= clr_idx_q + ADDR_W'(1);
            if (state_q == ST_IDLE && dump_kick && !clear_kick) iss_row_q <= '0;
            else if (issue)                                     iss_row_q <= iss_row_q + (ROW_W+1)'(1);

            // Two-slot output queue (out + hold) absorbs the in-flight read on a stall.
            if (!out_vld_q || pop) begin
                if (hold_vld_q) begin
                    out_vld_q   <= 1'b1;
                    out_data_q  <= hold_data_q;
                    out_last_q  <= hold_last_q;
                    hold_vld_q  <= rd_pend_q;
                    hold_data_q <= arr_data;
                    hold_last_q <= arr_last;
                end else if (rd_pend_q) begin
                    out_vld_q  <= 1'b1;
                    out_data_q <= arr_data;
                    out_last_q <= arr_last;
                end else begin
                    out_vld_q  <= 1'b0;
                    out_last_q <= 1'b0;
                end
            end else if (rd_pend_q) begin
                hold_vld_q  <= 1'b1;
                hold_data_q <= arr_data;
                hold_last_q <= arr_last;
            end
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign drop_count    = drop_q;
    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
endmodule

// File: tb/tb_accum_array.sv
// Randomized bench for accum_array against an array-of-counters reference model.
module tb_accum_array;
    localparam int DEPTH = 64;

    logic         clk = 1'b0;
    logic         reset, accum_we, clear_kick, dump_kick, m_axis_tready;
    logic [31:0]  accum_addr, dump_words;
    logic [63:0]  accum_din;
    logic         busy, m_axis_tvalid, m_axis_tlast;
    logic [31:0]  drop_count;
    logic [511:0] m_axis_tdata;

    always #5 clk = ~clk;

    accum_array #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .accum_addr(accum_addr), .accum_din(accum_din),
        .accum_we(accum_we), .clear_kick(clear_kick), .dump_kick(dump_kick),
        .dump_words(dump_words), .busy(busy), .drop_count(drop_count),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    logic [63:0] model [DEPTH];
    int unsigned mdrop;
    int          nvec = 0, nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    // ok: the bench expects the block to be in an accepting phase for this strobe
    task automatic strobe(input logic [31:0] a, input logic [63:0] d, input bit ok);
        accum_we = 1'b1; accum_addr = a; accum_din = d;
        tick;
        accum_we = 1'b0;
        if (ok && a < DEPTH) model[a] += d;
        else                 mdrop++;
    endtask

    task automatic rand_burst(input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick;
            case ($urandom_range(0, 7))
                0:       a = DEPTH + $urandom_range(0, 100);
                1, 2, 3: a = $urandom_range(0, 3);
                default: a = $urandom_range(0, DEPTH-1);
            endcase
            strobe(a, {$urandom, $urandom}, 1'b1);
        end
    endtask

    task automatic do_clear(input bit with_dump, input bit strobe_in_clear);
        int n;
        clear_kick = 1'b1; dump_kick = with_dump; dump_words = 8;
        tick;
        clear_kick = 1'b0; dump_kick = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < DEPTH + 20) begin
            accum_we = strobe_in_clear && n == 3; accum_addr = 1; accum_din = 5;
            dump_kick = (n == 10);
            tick;
            n++;
        end
        accum_we = 1'b0; dump_kick = 1'b0;
        if (strobe_in_clear) mdrop++;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        chk("clr_cycles", 64'(n), 64'(DEPTH));
        tick; tick;
        chk("clr_stays_idle", 64'(busy), 64'd0);
        chk("clr_drop", 64'(drop_count), 64'(mdrop));
    endtask

    task automatic do_dump(input int unsigned words, input bit rnd_rdy, input bit drain_strb);
        int unsigned wc, nb, b, c, last_c, idx, n;
        logic [31:0]  a;
        logic [63:0]  d;
        logic         pv, pr;
        logic [511:0] pd;
        wc = (words > DEPTH) ? DEPTH : words;
        nb = (wc + 7) / 8;
        dump_kick = 1'b1; dump_words = words;
        tick;
        dump_kick = 1'b0; dump_words = $urandom;
        if (nb == 0) begin
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                chk("nb0_tvalid", 64'(m_axis_tvalid), 64'd0);
                tick;
                n++;
            end
            chk("nb0_cycles", 64'(n), 64'd2);
            return;
        end
        b = 0; c = 0; last_c = 0; pv = 1'b0; pr = 1'b0; pd = '0;
        while (b < nb && c < 4000) begin
            m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drain_strb && c < 3) begin
                a = $urandom_range(0, DEPTH-1); d = {$urandom, $urandom};
                accum_we = 1'b1; accum_addr = a; accum_din = d;
                if (c < 2) model[a] += d;
                else       mdrop++;
            end
            @(negedge clk);
            if (pv && !pr) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_tdata", 64'(m_axis_tdata == pd), 64'd1);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                for (int l = 0; l < 8; l++) begin
                    idx = b * 8 + l;
                    chk($sformatf("beat%0d_lane%0d", b, l), m_axis_tdata[l*64 +: 64],
                        (idx < wc) ? model[idx] : 64'd0);
                end
                chk("tlast", 64'(m_axis_tlast), 64'(b == nb - 1));
                if (!rnd_rdy) begin
                    if (b == 0) chk("first_latency_ok", 64'(c <= 12), 64'd1);
                    else        chk("rate", 64'(c), 64'(last_c + 1));
                end
                last_c = c;
                b++;
            end
            pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata;
            tick;
            accum_we = 1'b0;
            c++;
        end
        m_axis_tready = 1'b0;
        chk("beats", 64'(b), 64'(nb));
        chk("dump_done_busy", 64'(busy), 64'd0);
        chk("dump_done_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("dump_drop", 64'(drop_count), 64'(mdrop));
    endtask

    initial begin
        int n;
        reset = 1'b1; accum_we = 1'b0; clear_kick = 1'b0; dump_kick = 1'b0;
        m_axis_tready = 1'b0; accum_addr = '0; accum_din = '0; dump_words = '0;
        mdrop = 0;
        repeat (3) tick;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b0;
        tick;

        do_clear(1'b0, 1'b0);
        repeat (4) strobe(5, 64'd1, 1'b1);
        do_dump(8, 1'b0, 1'b0);

        do_clear(1'b0, 1'b0);
        strobe(3, 64'd2, 1'b1); strobe(3, 64'd2, 1'b1);
        strobe(7, 64'd2, 1'b1); strobe(3, 64'd2, 1'b1);
        do_dump(8, 1'b0, 1'b0);

        do_clear(1'b0, 1'b0);
        strobe(0, '1, 1'b1); strobe(0, 64'd2, 1'b1);
        do_dump(8, 1'b0, 1'b0);

        // out-of-range strobe, then a strobe during clear
        do_clear(1'b0, 1'b0);
        strobe(DEPTH, 64'd9, 1'b1);
        do_dump(8, 1'b0, 1'b0);
        do_clear(1'b0, 1'b1);
        chk("drop_two", 64'(drop_count), 64'd2);

        // simultaneous kicks: clear wins, dump discarded
        do_clear(1'b1, 1'b0);

        rand_burst(40);
        do_dump(20, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int unsigned w;
            rand_burst($urandom_range(10, 60));
            case (r % 4)
                0:       w = 0;
                1:       w = DEPTH + $urandom_range(0, 50);
                default: w = $urandom_range(1, DEPTH);
            endcase
            do_dump(w, r[0], 1'b1);
        end
        do_dump(DEPTH, 1'b0, 1'b1);

        // reset in the middle of a dump
        dump_kick = 1'b1; dump_words = DEPTH; m_axis_tready = 1'b0;
        tick;
        dump_kick = 1'b0;
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 20) begin tick; n++; end
        chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
        reset = 1'b1;
        tick;
        chk("mid_dump_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mid_dump_rst_busy", 64'(busy), 64'd0);
        chk("mid_dump_rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b0; mdrop = 0;
        tick;
        do_dump(16, 1'b1, 1'b0);

        // reset in the middle of a clear
        clear_kick = 1'b1;
        tick;
        clear_kick = 1'b0;
        repeat (5) tick;
        reset = 1'b1;
        tick;
        chk("mid_clr_rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick;
        do_clear(1'b0, 1'b0);
        rand_burst(30);
        do_dump($urandom_range(1, DEPTH), 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/accum_array.md
ACCUM_ARRAY -- requirements
Module: accum_array

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 64-bit counter entries, power of two, >= 8.
REQ-002 SHALL have localparam ADDR_W = clog2(DEPTH).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 accum_addr  input  32  entry index from the search-and-add stage.
REQ-006 accum_din  input  64  increment value.
REQ-007 accum_we  input  1  one-cycle write strobe; no backpressure.
REQ-008 clear_kick  input  1  pulse; zero all entries.
REQ-009 dump_kick  input  1  pulse; stream entries 0..dump_words-1.
REQ-010 dump_words  input  32  number of entries to dump; sampled on dump_kick.
REQ-011 busy  output  1  high from the kick-accept edge until the operation completes.
REQ-012 drop_count  output  32  count of discarded accum_we strobes.
REQ-013 m_axis_tvalid/m_axis_tready/m_axis_tdata[511:0]/m_axis_tlast  output/input/output/output  dump stream to the AXI write master.

Function
REQ-014 States SHALL be IDLE, CLEAR, DRAIN, DUMP; IDLE is the only state accepting kicks.
REQ-015 In IDLE, clear_kick -> CLEAR; dump_kick -> DRAIN; both asserted together -> CLEAR, dump_kick discarded.
REQ-016 A kick outside IDLE SHALL be ignored with no side effect.
REQ-017 Accumulation: 2-stage read-modify-write; a strobe at cycle N reads at N, writes mem[addr] + din at N+1, and is visible to a read at N+2.
REQ-018 Back-to-back strobes to the same address SHALL forward the stage-2 sum; no update is lost at full rate.
REQ-019 Sum SHALL wrap modulo 2^64; no saturation.
REQ-020 Strobes with accum_addr >= DEPTH, or arriving outside IDLE and DRAIN, SHALL be discarded and increment drop_count; drop_count wraps at 2^32.
REQ-021 CLEAR SHALL write zero to entries 0..DEPTH-1, one per cycle, then return to IDLE; busy deasserts the cycle after the last write.
REQ-022 DRAIN SHALL last exactly 2 cycles so in-flight updates land, then enter DUMP; strobes during DRAIN are still accumulated.
REQ-023 Each DUMP beat SHALL pack 8 consecutive entries, with the lowest index in tdata[63:0].
REQ-024 Beat count SHALL equal ceil(dump_words/8); lanes at or beyond dump_words SHALL be zero; tlast SHALL be set on the final beat only.
REQ-025 dump_words is clamped to DEPTH; dump_words = 0 SHALL produce no beats and return to IDLE after DRAIN.
REQ-026 AXI-Stream rule: once tvalid is high, tdata/tlast SHALL stay stable until tready; tvalid SHALL NOT drop before the handshake.
REQ-027 Entry reads SHALL be prefetched so that, with tready held high, beats are sustained at 1 per cycle after a first-beat latency of <= 10 cycles from DUMP entry.
REQ-028 DUMP SHALL return to IDLE the cycle after the tlast handshake.

Reset
REQ-029 Reset SHALL force IDLE, busy=0, tvalid=0, tlast=0, drop_count=0, and clear the RMW pipeline valid flags.
REQ-030 Reset SHALL NOT initialise RAM contents; software issues clear_kick before first use.
REQ-031 Reset mid-CLEAR or mid-DUMP SHALL abort the operation; tvalid is low in the cycle after reset is sampled.

Structure
REQ-032 A shared package SHALL hold the state enum, LANES=8, and ENTRY_W=64.
REQ-033 RAM SHALL be one sub-module, accum_ram: simple dual-port, 1-cycle read latency, DEPTH x 64, inferable as BRAM/URAM.
REQ-034 CLEAR writes and RMW writes share the RAM write port; the FSM guarantees they are mutually exclusive.

Verification
REQ-035 clear_kick, then 4 strobes (addr 5, din 1) on consecutive cycles, dump_words=8 -> one beat, lane5=4, other lanes 0, tlast=1.
REQ-036 Alternating strobes addr 3/addr 3/addr 7/addr 3, din 2, every cycle -> entry3=6, entry7=2 (forwarding check).
REQ-037 dump_words=20, tready toggled randomly -> 3 beats; beat 2 lanes 4..7 zero; data stable while stalled; tlast on beat 2 only.
REQ-038 Strobe addr=DEPTH, plus one strobe during CLEAR -> drop_count=2, no RAM change.
REQ-039 entry0 = 2^64-1, then strobe din=2 -> dump shows entry0=1.
REQ-040 Reset asserted mid-DUMP -> tvalid=0 next cycle, busy=0; a following dump_kick restarts from entry 0.
